// File: rtl/spi_reg_pkg.sv
// Shared constants and FSM state encoding for the SPI register bank.
// Combinational definitions only; no latency or backpressure of its own.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COMMIT   = 2'd1,
    S_WAIT_LOW = 2'd2
  } state_t;

  localparam int          REG_CTRL          = 0;
  localparam int          CTRL_SOFT_RST_BIT = 7;
  localparam logic [7:0]  RD_OOR_VALUE      = 8'hFF;
  localparam logic [7:0]  ERR_MAX           = 8'd255;

endpackage

// File: rtl/spi_reg_commit_fsm.sv
// Turns a level data_ready into exactly one commit pulse, capturing addr/data on the rising level.
// Commit pulse one cycle after data_ready is sampled high; no backpressure, re-arms only after data_ready drops.
module spi_reg_commit_fsm
  import spi_reg_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_ready,
  input  logic [ADDR_W-1:0] address_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              commit,
  output logic [ADDR_W-1:0] commit_addr,
  output logic [DATA_W-1:0] commit_data
);

  state_t state, state_nxt;
  logic   capture;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      commit_addr <= '0;
      commit_data <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        commit_addr <= address_in;
        commit_data <= data_in;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    commit    = 1'b0;
    case (state)
      S_IDLE: begin
        if (data_ready) begin
          state_nxt = S_COMMIT;
          capture   = 1'b1;
        end
      end
      S_COMMIT: begin
        commit    = 1'b1;
        state_nxt = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        if (!data_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: rtl/spi_reg_bank.sv
// Commits completed SPI transfers into an 8-bit register bank with strobes, error count, optional readback.
// Registers/strobes update one edge after data_ready is seen high; no backpressure. Readback via SPI_REG_READBACK_EN.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          address_in,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       data_ready,
  output logic [NUM_REGS*DATA_W-1:0] reg_out,
  output logic [NUM_REGS-1:0]        wr_strobe,
  output logic [7:0]                 err_count,
  input  logic [ADDR_W-1:0]          rd_address,
  output logic [DATA_W-1:0]          rd_data
);

  localparam logic [ADDR_W-1:0] NUM_REGS_A = ADDR_W'(NUM_REGS);

  logic                             commit;
  logic [ADDR_W-1:0]                commit_addr;
  logic [DATA_W-1:0]                commit_data;
  logic [NUM_REGS-1:0][DATA_W-1:0]  reg_q;
  logic [NUM_REGS-1:0]              hit;
  logic                             in_range;
  logic                             soft_rst;
  logic [DATA_W-1:0]                ctrl_val;

  spi_reg_commit_fsm #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_commit_fsm (
    .clk         (clk),
    .rst         (rst),
    .data_ready  (data_ready),
    .address_in  (address_in),
    .data_in     (data_in),
    .commit      (commit),
    .commit_addr (commit_addr),
    .commit_data (commit_data)
  );

  always_comb begin
    hit      = '0;
    in_range = commit_addr < NUM_REGS_A;
    for (int k = 0; k < NUM_REGS; k++) begin
      hit[k] = commit && (commit_addr == ADDR_W'(k));
    end
    soft_rst = hit[REG_CTRL] && commit_data[CTRL_SOFT_RST_BIT];
    // The soft-reset bit is a command, never stored state.
    ctrl_val = commit_data;
    ctrl_val[CTRL_SOFT_RST_BIT] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_q     <= '0;
      wr_strobe <= '0;
      err_count <= '0;
    end else begin
      wr_strobe <= hit;
      for (int k = 0; k < NUM_REGS; k++) begin
        if (hit[k]) begin
          reg_q[k] <= (k == REG_CTRL) ? ctrl_val : commit_data;
        end else if (soft_rst && k != REG_CTRL) begin
          reg_q[k] <= '0;
        end
      end
      if (soft_rst) begin
        err_count <= '0;
      end else if (commit && !in_range && err_count != ERR_MAX) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

  assign reg_out = reg_q;

`ifdef SPI_REG_READBACK_EN
  logic [DATA_W-1:0] rd_mux;

  always_comb begin
    rd_mux = DATA_W'(RD_OOR_VALUE);
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rd_address == ADDR_W'(k)) rd_mux = reg_q[k];
    end
  end

  // Samples the pre-edge bank, so a same-cycle write shows up one read later.
  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= rd_mux;
  end
`else
  logic unused_rd_address;
  assign unused_rd_address = ^rd_address;
  assign rd_data = '0;
`endif

endmodule
